// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, FSM state encoding and parity helper for
//               the parametrised UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_t;

    // Unused upper bits must be zero so they do not disturb the XOR.
    function automatic logic expected_parity(input logic [MAX_DATA_BITS-1:0] data,
                                             input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : Line synchroniser, falling-edge detect and bit voter.
//               Macro UART_RX_MAJORITY_EN selects a 2-of-3 vote.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler (
    input  logic baud_clk,
    input  logic reset_n,
    input  logic rx_data_in,
    output logic rxs,
    output logic fall,
    output logic bit_val
);

    logic r_sync1;
    logic r_sync2;
    logic r_d1;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_d1    <= 1'b1;
        end else begin
            r_sync1 <= rx_data_in;
            r_sync2 <= r_sync1;
            r_d1    <= r_sync2;
        end
    end

    assign rxs  = r_sync2;
    assign fall = r_d1 & ~r_sync2;

`ifdef UART_RX_MAJORITY_EN
    logic r_d2;

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d2 <= 1'b1;
        end else begin
            r_d2 <= r_d1;
        end
    end

    // r_d1 is the centre sample; its neighbours vote with it.
    assign bit_val = (r_d2 & r_d1) | (r_d2 & r_sync2) | (r_d1 & r_sync2);
`else
    // Same centre sample as the voting build, so timing is identical.
    assign bit_val = r_d1;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx_param.sv
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver with valid/ready
//               output. Optional macro: UART_RX_MAJORITY_EN (2-of-3 voting).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 baud_clk,
    input  logic                 reset_n,
    input  logic                 rx_data_in,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 rx_busy
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(MAX_DATA_BITS + 1);
    localparam int MID = OVERSAMPLE / 2 - 1;

    logic rxs;
    logic fall;
    logic bit_val;

    uart_rx_sampler u_sampler (
        .baud_clk   (baud_clk),
        .reset_n    (reset_n),
        .rx_data_in (rx_data_in),
        .rxs        (rxs),
        .fall       (fall),
        .bit_val    (bit_val)
    );

    rx_state_t               r_state,   w_state_nxt;
    logic [CW-1:0]           r_cnt,     w_cnt_nxt;
    logic [BW-1:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [DATA_BITS-1:0]    r_shift,   w_shift_nxt;
    logic                    r_par_err, w_par_err_nxt;
    logic                    r_frm_err, w_frm_err_nxt;
    logic [DATA_BITS-1:0]    w_data_nxt;
    logic                    w_valid_nxt, w_perr_nxt, w_ferr_nxt, w_ovr_nxt;
    logic [MAX_DATA_BITS-1:0] w_ext;

    always_comb begin
        w_ext                = '0;
        w_ext[DATA_BITS-1:0] = r_shift;
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_err   <= 1'b0;
            r_frm_err   <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_par_err   <= w_par_err_nxt;
            r_frm_err   <= w_frm_err_nxt;
            rx_data     <= w_data_nxt;
            rx_valid    <= w_valid_nxt;
            parity_err  <= w_perr_nxt;
            frame_err   <= w_ferr_nxt;
            overrun_err <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_cnt == CW'(OVERSAMPLE - 1)) ? '0 : r_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_par_err_nxt = r_par_err;
        w_frm_err_nxt = r_frm_err;
        w_data_nxt    = rx_data;
        w_valid_nxt   = rx_valid;
        w_perr_nxt    = parity_err;
        w_ferr_nxt    = frame_err;
        w_ovr_nxt     = 1'b0;

        if (rx_valid && rx_ready) begin
            w_valid_nxt = 1'b0;
            w_perr_nxt  = 1'b0;
            w_ferr_nxt  = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                // The detection cycle itself is tick 0 of the start bit.
                if (fall) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = CW'(1);
                end
            end
            ST_START: begin
                if (r_cnt == CW'(MID)) begin
                    w_cnt_nxt = '0;
                    if (!bit_val) begin
                        w_state_nxt   = ST_DATA;
                        w_bit_cnt_nxt = '0;
                        w_par_err_nxt = 1'b0;
                        w_frm_err_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (r_cnt == CW'(OVERSAMPLE - 1)) begin
                    w_shift_nxt = {bit_val, r_shift[DATA_BITS-1:1]};
                    if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (r_cnt == CW'(OVERSAMPLE - 1)) begin
                    w_par_err_nxt = bit_val ^ expected_parity(w_ext, PARITY_MODE);
                    w_state_nxt   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (r_cnt == CW'(OVERSAMPLE - 1)) begin
                    w_frm_err_nxt = r_frm_err | ~bit_val;
                    if (r_bit_cnt == BW'(STOP_BITS - 1)) begin
                        w_bit_cnt_nxt = '0;
                        w_data_nxt    = r_shift;
                        w_perr_nxt    = r_par_err;
                        w_ferr_nxt    = r_frm_err | ~bit_val;
                        w_valid_nxt   = 1'b1;
                        w_ovr_nxt     = rx_valid & ~rx_ready;
                        // A line still low here is a break; wait for idle.
                        w_state_nxt   = rxs ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receiver; successor to the fixed 8N1, one-sample-per-bit receiver.
- Adds configurable data width, parity and stop bits, plus mid-bit sampling at OVERSAMPLE ticks per bit.
- Adds a valid/ready output handshake with parity, framing and overrun status.
- Sits between the pad-side serial input and the RX FIFO / register interface.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, baud_clk cycles per bit; even, >=4.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.

Ports:
- baud_clk  in  1  single clock, OVERSAMPLE × bit rate.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data_in  in  1  asynchronous serial line; idles high.
- rx_ready  in  1  consumer accepts the held word.
- rx_data  out  DATA_BITS  received word, LSB first on the line.
- rx_valid  out  1  word available; held until accepted.
- parity_err  out  1  parity mismatch for the held word.
- frame_err  out  1  a stop bit sampled low for the held word.
- overrun_err  out  1  one-cycle pulse: unaccepted word overwritten.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, baud_clk; reset_n is asynchronous, active-low.
- Reset: all outputs 0; FSM in IDLE; synchroniser flops preset to 1 (idle line).
- Input path: 2-flop synchroniser on rx_data_in. All decisions use the synchronised value `rxs`.
- Tick counter: cnt runs 0..OVERSAMPLE-1. The mid-bit sample is taken at cnt == OVERSAMPLE/2-1, measured from start-edge detection.
- IDLE: falling edge of rxs -> START, cnt = 0.
- START: at the mid sample, rxs = 0 -> DATA with cnt rebased so later samples fall every OVERSAMPLE cycles. rxs = 1 -> false start, back to IDLE with no outputs changed.
- DATA: one sample per bit period, shifted in LSB first. After DATA_BITS samples -> PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample the parity bit. Expected value is XOR of the data bits for even, its inverse for odd; the mismatch is latched internally.
- STOP: sample STOP_BITS stop bits; any low sample sets an internal frame flag.
- Output update: on the edge of the final stop-bit sample, the FSM updates rx_data, parity_err, frame_err and sets rx_valid in one cycle.
- After STOP: returns to IDLE if rxs = 1. If rxs = 0 (break or frame error) -> WAIT_IDLE, which returns to IDLE only once rxs is high, so a held-low line cannot retrigger.
- Latency: rx_valid rises at the final stop-bit mid-sample. That is (1 + DATA_BITS + P + STOP_BITS - 1) × OVERSAMPLE + OVERSAMPLE/2 + 2 cycles after the line's falling edge; P = 1 if parity is enabled. This equals 154 cycles for 8N1, OVERSAMPLE = 16.
- Handshake: rx_valid & rx_ready on an edge clears rx_valid, parity_err and frame_err at that edge. rx_ready while rx_valid = 0 is ignored.
- Overrun: a frame completes while rx_valid = 1 and rx_ready = 0. Then rx_data and the error flags are overwritten, rx_valid stays 1 and overrun_err pulses for one cycle.
- Completion with rx_ready = 1 in the same cycle: the old word is consumed, the new word loads, rx_valid stays 1 and there is no overrun.
- rx_data is left unchanged by a false start.
- Reset mid-frame: everything clears immediately; the partial frame is discarded.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined: each bit, including start, is the 2-of-3 majority of samples at mid-1, mid and mid+1. Single-cycle glitches are rejected.
- Undefined: a single sample at mid. Timing and latency are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants;
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - a parity function.
- Sub-module uart_rx_sampler holds the synchroniser, the falling-edge detect and the majority filter. It outputs `rxs`, `fall` and the voted bit. The top holds the FSM, counters, shift register and handshake.

Test Plan:
- 8N1, OVERSAMPLE = 16: send 0xA5, rx_ready held 1. Expect rx_data = 0xA5, rx_valid pulse of 1 cycle at fall+154, no error flags.
- PARITY_MODE = 1: send 0xC3 with parity bit 1 (correct is 0). Expect rx_data = 0xC3, parity_err = 1; then send 0xC3 with parity 0 and expect parity_err = 0.
- Send 0x3C with the stop bit driven low, followed by 40 low cycles. Expect frame_err = 1 and rx_busy high until the line returns high. A following 0x55 is received cleanly.
- rx_ready = 0: send 0xA5 then 0xD5. Expect overrun_err single pulse at the second completion, rx_data = 0xD5, rx_valid held; raising rx_ready clears rx_valid next edge.
- Glitch low for 3 cycles on an idle line. Expect a false start: no rx_valid and rx_busy back to 0 within 10 cycles. With UART_RX_MAJORITY_EN, a 1-cycle glitch inside a data bit of 0xFF still yields 0xFF.
- Assert reset_n = 0 for 2 cycles mid-DATA of 0xA5. Expect all outputs 0 immediately; the next full frame 0x81 is received correctly.
